// File: rtl/sr_cmd_driver.sv
// Command driver for the gated SR latch: synchronizes, debounces and
// edge-detects raw set/reset requests and emits clean one-hot pulses.

module sr_cmd_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic req
);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer for the asynchronous raw line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Rising-edge detect of the debounced level, registered to one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
            req  <= 1'b0;
        end else begin
            prev <= deb;
            req  <= deb & ~prev;
        end
    end

endmodule

module sr_cmd_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic reset_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DRIVE_S = 2'd1;
    localparam logic [1:0] DRIVE_R = 2'd2;
    localparam logic [1:0] GAP     = 2'd3;

    logic             req_s;
    logic             req_r;
    logic             pend_s;
    logic             pend_r;
    logic             want_s;
    logic             want_r;
    logic             take_s;
    logic             take_r;
    logic [1:0]       state;
    logic [CNT_W-1:0] pcnt;

    sr_cmd_cond #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set (
        .clk (clk),
        .rst (rst),
        .raw (set_in),
        .req (req_s)
    );

    sr_cmd_cond #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_reset (
        .clk (clk),
        .rst (rst),
        .raw (reset_in),
        .req (req_r)
    );

    // A request counts whether it is fresh this cycle or parked earlier.
    assign want_s = pend_s | req_s;
    assign want_r = pend_r | req_r;

    // IDLE consumes whatever it acts on; a conflict consumes both.
    assign take_s = (state == IDLE) & want_s;
    assign take_r = (state == IDLE) & want_r;

    // One-deep pending flags; repeats while parked merge into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_s <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            pend_s <= take_s ? 1'b0 : (pend_s | req_s);
            pend_r <= take_r ? 1'b0 : (pend_r | req_r);
        end
    end

    // Command FSM with registered outputs; s and r are never both set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            conflict <= 1'b0;
            case (state)
                IDLE: begin
                    if (want_s && want_r) begin
                        conflict <= 1'b1;
                    end else if (want_s) begin
                        state <= DRIVE_S;
                        pcnt  <= '0;
                        s     <= 1'b1;
                        busy  <= 1'b1;
                    end else if (want_r) begin
                        state <= DRIVE_R;
                        pcnt  <= '0;
                        r     <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                DRIVE_S, DRIVE_R: begin
                    if (pcnt == CNT_W'(PULSE_CYCLES - 1)) begin
                        state <= GAP;
                        s     <= 1'b0;
                        r     <= 1'b0;
                    end else begin
                        pcnt <= pcnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    s     <= 1'b0;
                    r     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver: default build plus a P=1/D=1 build,
// pulses compared against an expected-event scoreboard.

module tb_sr_cmd_driver;

    typedef struct packed {
        logic [1:0] kind;
        int         start;
        int         len;
    } ev_t;

    localparam logic [1:0] K_S = 2'd0;
    localparam logic [1:0] K_R = 2'd1;
    localparam logic [1:0] K_C = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] set_v = 2'b00;
    logic [1:0] res_v = 2'b00;
    logic [1:0] s_v;
    logic [1:0] r_v;
    logic [1:0] busy_v;
    logic [1:0] conf_v;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    ev_t q0[$];
    ev_t q1[$];

    int srun[2];
    int sst[2];
    int slen[2];
    int rrun[2];
    int rst_st[2];
    int rlen[2];
    int blen[2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    sr_cmd_driver dut0 (
        .clk      (clk),
        .rst      (rst),
        .set_in   (set_v[0]),
        .reset_in (res_v[0]),
        .s        (s_v[0]),
        .r        (r_v[0]),
        .busy     (busy_v[0]),
        .conflict (conf_v[0])
    );

    sr_cmd_driver #(
        .DEBOUNCE_CYCLES (1),
        .PULSE_CYCLES    (1),
        .CNT_W           (8)
    ) dut1 (
        .clk      (clk),
        .rst      (rst),
        .set_in   (set_v[1]),
        .reset_in (res_v[1]),
        .s        (s_v[1]),
        .r        (r_v[1]),
        .busy     (busy_v[1]),
        .conflict (conf_v[1])
    );

    function automatic int plen_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic push_ev(input int k, input logic [1:0] kind,
                           input int st, input int ln);
        ev_t e;
        e = '{kind: kind, start: st, len: ln};
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic check_event(input int k, input logic [1:0] kind,
                               input int st, input int ln);
        ev_t got;
        ev_t exp_e;
        int  qsz;
        got = '{kind: kind, start: st, len: ln};
        qsz = (k == 0) ? q0.size() : q1.size();
        vectors++;
        assert (qsz !== 0) else begin
            miscompares++;
            $error("FAIL unexpected_event dut%0d observed kind=%0d start=%0d len=%0d expected none",
                   k, kind, st, ln);
        end
        if (qsz != 0) begin
            exp_e = (k == 0) ? q0.pop_front() : q1.pop_front();
            assert (got === exp_e) else begin
                miscompares++;
                $error("FAIL event dut%0d observed kind=%0d start=%0d len=%0d expected kind=%0d start=%0d len=%0d",
                       k, got.kind, got.start, got.len,
                       exp_e.kind, exp_e.start, exp_e.len);
            end
        end
    endtask

    // Output monitor: invariants every cycle, pulses matched to scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                srun[k] = 0;
                rrun[k] = 0;
                blen[k] = 0;
            end else begin
                vectors++;
                assert ((s_v[k] & r_v[k]) === 1'b0) else begin
                    miscompares++;
                    $error("FAIL s_and_r dut%0d observed s=%b r=%b expected not both",
                           k, s_v[k], r_v[k]);
                end
                vectors++;
                assert ((conf_v[k] & (s_v[k] | r_v[k])) === 1'b0) else begin
                    miscompares++;
                    $error("FAIL conflict_with_drive dut%0d observed c=%b s=%b r=%b expected 0",
                           k, conf_v[k], s_v[k], r_v[k]);
                end
                if (s_v[k] | r_v[k]) begin
                    vectors++;
                    assert (busy_v[k] === 1'b1) else begin
                        miscompares++;
                        $error("FAIL busy_in_drive dut%0d observed %b expected 1",
                               k, busy_v[k]);
                    end
                end
                if (s_v[k]) begin
                    if (srun[k] == 0) begin
                        srun[k] = 1;
                        sst[k]  = cyc;
                        slen[k] = 1;
                    end else begin
                        slen[k]++;
                    end
                end else if (srun[k] != 0) begin
                    srun[k] = 0;
                    check_event(k, K_S, sst[k], slen[k]);
                end
                if (r_v[k]) begin
                    if (rrun[k] == 0) begin
                        rrun[k]   = 1;
                        rst_st[k] = cyc;
                        rlen[k]   = 1;
                    end else begin
                        rlen[k]++;
                    end
                end else if (rrun[k] != 0) begin
                    rrun[k] = 0;
                    check_event(k, K_R, rst_st[k], rlen[k]);
                end
                if (conf_v[k]) check_event(k, K_C, cyc, 1);
                if (busy_v[k]) begin
                    blen[k]++;
                end else if (blen[k] != 0) begin
                    vectors++;
                    assert (blen[k] === plen_of(k) + 1) else begin
                        miscompares++;
                        $error("FAIL busy_len dut%0d observed %0d expected %0d",
                               k, blen[k], plen_of(k) + 1);
                    end
                    blen[k] = 0;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c;
        // reset state
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            assert ({s_v[k], r_v[k], busy_v[k], conf_v[k]} === 4'b0000) else begin
                miscompares++;
                $error("FAIL reset_outputs dut%0d observed %b expected 0000",
                       k, {s_v[k], r_v[k], busy_v[k], conf_v[k]});
            end
        end
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(3);

        // clean set held long: one 2-cycle s pulse after 8 edges
        c = cyc;
        set_v[0] = 1'b1;
        push_ev(0, K_S, c + 8, 2);
        wait_cyc(20);
        set_v[0] = 1'b0;
        wait_cyc(10);

        // short reset glitch: nothing
        res_v[0] = 1'b1;
        wait_cyc(2);
        res_v[0] = 1'b0;
        wait_cyc(12);

        // simultaneous requests: one conflict pulse
        c = cyc;
        set_v[0] = 1'b1;
        res_v[0] = 1'b1;
        push_ev(0, K_C, c + 8, 1);
        wait_cyc(20);
        set_v[0] = 1'b0;
        res_v[0] = 1'b0;
        wait_cyc(12);

        // reset request raised while s is driving
        c = cyc;
        set_v[0] = 1'b1;
        push_ev(0, K_S, c + 8, 2);
        wait_cyc(8);
        res_v[0] = 1'b1;
        push_ev(0, K_R, c + 16, 2);
        wait_cyc(20);
        set_v[0] = 1'b0;
        res_v[0] = 1'b0;
        wait_cyc(12);

        // async reset in the middle of an r pulse
        c = cyc;
        res_v[0] = 1'b1;
        wait_cyc(8);
        #2;
        vectors++;
        assert (r_v[0] === 1'b1) else begin
            miscompares++;
            $error("FAIL r_before_abort observed %b expected 1", r_v[0]);
        end
        rst = 1'b1;
        #1;
        vectors++;
        assert ({s_v[0], r_v[0], busy_v[0]} === 3'b000) else begin
            miscompares++;
            $error("FAIL async_abort observed s,r,busy=%b expected 000",
                   {s_v[0], r_v[0], busy_v[0]});
        end
        wait_cyc(2);
        rst = 1'b0;
        c = cyc;
        push_ev(0, K_R, c + 8, 2);
        wait_cyc(20);
        res_v[0] = 1'b0;
        wait_cyc(12);

        // P=1, D=1 build: first pulse after 5 edges, pending repeat 3 later
        c = cyc;
        set_v[1] = 1'b1;
        push_ev(1, K_S, c + 5, 1);
        wait_cyc(1);
        set_v[1] = 1'b0;
        wait_cyc(1);
        set_v[1] = 1'b1;
        push_ev(1, K_S, c + 8, 1);
        wait_cyc(15);
        set_v[1] = 1'b0;
        wait_cyc(10);

        // every expected event must have been seen
        vectors++;
        assert (q0.size() === 0) else begin
            miscompares++;
            $error("FAIL missing_events dut0 observed %0d left expected 0", q0.size());
        end
        vectors++;
        assert (q1.size() === 0) else begin
            miscompares++;
            $error("FAIL missing_events dut1 observed %0d left expected 0", q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sr_cmd_driver.md
Name: sr_cmd_driver

Overview:
- Upstream command stage for the gated SR latch.
- Takes two raw, possibly bouncy asynchronous request lines (set_in, reset_in), then synchronizes, debounces and edge-detects them.
- Emits clean, one-hot, fixed-width s/r pulses.
- Guarantees the forbidden s=r=1 code never reaches the latch; simultaneous requests are flagged instead.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized input must differ from its debounced level before that level flips; legal range 1..255.
- PULSE_CYCLES, 2: cycles s or r is held high per command; legal range 1..255.
- CNT_W, 8: width of the debounce and pulse counters; must hold max(DEBOUNCE_CYCLES, PULSE_CYCLES).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- set_in  input  1  raw set request, asynchronous to clk.
- reset_in  input  1  raw reset request, asynchronous to clk.
- s  output  1  registered set drive to latch.
- r  output  1  registered reset drive to latch.
- busy  output  1  registered; high whenever FSM is not IDLE.
- conflict  output  1  registered one-cycle pulse: set and reset requests resolved in the same cycle; nothing driven.

Behaviour:
- Reset (async, rst=1):
  - s=0, r=0, busy=0, conflict=0.
  - Synchronizer flops, debounced levels, previous-level flops, counters and pending flags all 0.
  - FSM=IDLE.
  - Takes effect immediately, including mid-pulse: s/r drop without completing the pulse.
- Synchronizer: two flops per input; sync_x is raw input delayed by 2 edges.
- Debounce, per input, independently:
  - If sync_x == deb_x, counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, deb_x <= sync_x and the counter clears.
  - deb_x therefore changes DEBOUNCE_CYCLES edges after sync_x.
  - A shorter glitch resets the counter and produces no change.
- Request: deb_x rising edge (deb_x=1, prev_x=0) gives a one-cycle req_x. Falling edges are ignored.
- Pending flags:
  - req_x sets pend_x; pend_x clears when consumed by the FSM.
  - Each flag is one deep; repeated requests while pending merge into one.
- FSM states: IDLE, DRIVE_S, DRIVE_R, GAP. Transitions out of IDLE use pend_x OR req_x of the current cycle:
  - Set only → DRIVE_S; s=1 from the next edge; pulse counter loaded; pend_s cleared.
  - Reset only → DRIVE_R; r=1 from the next edge; pend_r cleared.
  - Both → stay IDLE, conflict=1 for exactly one cycle, both pend flags cleared, s=r=0.
  - Neither → stay IDLE.
- DRIVE_S / DRIVE_R:
  - Output held exactly PULSE_CYCLES cycles, then → GAP with s=r=0.
  - Opposite requests arriving meanwhile are only recorded in pend flags.
- GAP: exactly one cycle of s=r=0 (latch hold code), then → IDLE.
- Back-to-back commands: minimum spacing between pulse starts is PULSE_CYCLES+2 cycles.
- Invariants:
  - s&r==0 on every cycle.
  - conflict never coincides with s or r.
  - busy=1 exactly in DRIVE_S, DRIVE_R and GAP.
- Latency: raw input sampled high at edge 1 with a clean level gives s (or r) high after edge DEBOUNCE_CYCLES+4. With defaults, s is visible after edge 8.
- Input held high across reset release: deb starts at 0, so one command is issued after normal latency.
- Input held high indefinitely: only one command is issued.

Test Plan:
- Reset, then set_in 0→1 held 20 cycles (defaults) → s=1 for exactly 2 cycles starting after edge 8; r stays 0; busy high 3 cycles; no second pulse.
- reset_in high for 2 cycles, then low (glitch shorter than 4) → s=r=0 throughout; busy=0; conflict=0.
- set_in and reset_in rising on the same edge, both held → conflict=1 for exactly 1 cycle; s=r=0 for the entire test.
- set_in rises; while DRIVE_S is active, reset_in is raised and debounced → s pulse (2 cycles), one GAP cycle with s=r=0, then r pulse (2 cycles); s&r never 1.
- rst asserted asynchronously mid-DRIVE_R, between clock edges → r and busy drop immediately; after release with reset_in still high, exactly one new r pulse follows after the full latency.
- Run with PULSE_CYCLES=1, DEBOUNCE_CYCLES=1 → single-cycle s pulse after edge 5 following a clean set_in rise; spacing between repeated commands ≥3 cycles.
